iq_comp_adapt: RTL
==================

IQ_COMP_ADAPT -- requirements
Module: iq_comp_adapt

Interface
REQ-001 Parameter DW, 4, I/Q sample width (unsigned offset-binary in, signed out).
REQ-002 Parameter WW, 13, signed weight width for Wr/Wj.
REQ-003 Parameter MU, 9, compensation arithmetic right-shift, so a weight of 2^MU means unity.
REQ-004 Parameter SETTLE_CNT, 64, consecutive small-update samples required to declare settled.
REQ-005 Parameter SETTLE_THR, 4, max |dWr| and |dWj| counted as a small update.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 op_mode  in  2  00 BYPASS, 01 INT_W, 10 EXT_W, 11 CONT_W.
REQ-009 freeze_iqcomp  in  1  holds weights in INT_W.
REQ-010 in_valid  in  1  Ix/Qx qualifier.
REQ-011 Ix, Qx  in  DW  raw unsigned samples.
REQ-012 Wr_in, Wj_in  in  WW  external weights, used in EXT_W.
REQ-013 out_valid  out  1  Iy/Qy qualifier.
REQ-014 Iy, Qy  out  DW signed  compensated samples.
REQ-015 Wr, Wj  out  WW signed  current weights.
REQ-016 settled  out  1  weights converged; tells the MCU to store Wr/Wj.

Function
REQ-017 Ix_s = Ix - 2^(DW-1); same for Qx_s.
REQ-018 I_c = Ix_s + ((Wr_use*Ix_s + Wj_use*Qx_s) >>> MU); Q_c = Qx_s + ((Wj_use*Ix_s - Wr_use*Qx_s) >>> MU); products at full width, then saturate to DW signed.
REQ-019 Wr_use/Wj_use = Wr_in/Wj_in in EXT_W, otherwise the internal Wr/Wj.
REQ-020 Latency: Iy/Qy/out_valid register one cycle after in_valid; out_valid = registered in_valid; Iy/Qy hold while in_valid = 0.
REQ-021 BYPASS: Iy = Ix_s, Qy = Qx_s; Wr = Wj = 0.
REQ-022 Weight update on in_valid only: Wr_n = Wr - (Iy+Qy)*(Iy-Qy); Wj_n = Wj - 2*Iy*Qy; uses the currently registered Iy/Qy; saturates to WW signed.
REQ-023 FSM states: ST_BYP, ST_ADAPT, ST_HOLD, ST_EXT, ST_TRACK.
REQ-024 Transitions: op_mode 00→ST_BYP, 10→ST_EXT, 11→ST_TRACK, 01→ST_ADAPT. ST_ADAPT→ST_HOLD when freeze_iqcomp = 1 or settled = 1. ST_HOLD→ST_ADAPT when freeze_iqcomp = 0 and settled = 0. op_mode is evaluated every cycle and has priority over all other transitions.
REQ-025 ST_ADAPT and ST_TRACK update the weights. ST_HOLD holds them. ST_EXT sets Wr/Wj = Wr_in/Wj_in each cycle. ST_TRACK ignores freeze_iqcomp and settled.
REQ-026 Weights are retained across non-BYPASS mode changes; entering INT_W from EXT_W adapts starting from the last external weights.
REQ-027 Any op_mode change clears the settle counter and settled in the same cycle.
REQ-028 Simultaneous freeze assertion and in_valid in ST_ADAPT: that sample's update is suppressed.

Reset
REQ-029 With RESET = 1 at a clock edge: Iy = Qy = 0, Wr = Wj = 0, out_valid = 0, settled = 0, settle counter = 0, state = ST_BYP, regardless of the current state or any in-flight sample.
REQ-030 First state after RESET releases is chosen from op_mode on the next edge.

Configuration
REQ-031 With IQCOMP_SETTLE_DET_EN defined: in ST_ADAPT, the counter increments on each valid update with |dWr| ≤ SETTLE_THR and |dWj| ≤ SETTLE_THR, and clears on any larger update. The counter saturates. settled = 1 when count = SETTLE_CNT and is sticky until an op_mode change or RESET.
REQ-032 Without IQCOMP_SETTLE_DET_EN: no counter is instantiated; settled = freeze_iqcomp combinationally; ST_ADAPT→ST_HOLD only on freeze.

Verification
REQ-033 BYPASS, Ix=12, Qx=3, in_valid pulse → next cycle Iy=4, Qy=-5, out_valid=1, Wr=Wj=0.
REQ-034 EXT_W, Wr_in=512, Wj_in=0, Ix=10, Qx=8 → Iy=4, Qy=0; Wr=512.
REQ-035 EXT_W, Wr_in=4095, Wj_in=0, Ix=15, Qx=8 → Iy saturates to 7, Qy=0.
REQ-036 After RESET, INT_W, samples Ix=11/Qx=9 twice → first output Iy=3, Qy=1 with W=0; after the second valid, Wr=-8, Wj=-6; with freeze=1, Wr/Wj unchanged.
REQ-037 IQCOMP_SETTLE_DET_EN on, INT_W, Ix=Qx=8 for 64 valid samples → settled=1 on the 64th update, state ST_HOLD; op_mode pulse to 11 → settled=0.
REQ-038 RESET asserted mid-ST_TRACK with in_valid=1 → next cycle all outputs 0 and state ST_BYP.

Source files
------------

// File: rtl/iq_comp_adapt.sv
// I/Q imbalance compensator with adaptive weights (Wr/Wj).
// Define IQCOMP_SETTLE_DET_EN to build the weight-settle detector.
module iq_comp_adapt #(
    parameter int DW         = 4,
    parameter int WW         = 13,
    parameter int MU         = 9,
    parameter int SETTLE_CNT = 64,
    parameter int SETTLE_THR = 4
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [1:0]           op_mode,
    input  logic                 freeze_iqcomp,
    input  logic                 in_valid,
    input  logic [DW-1:0]        Ix,
    input  logic [DW-1:0]        Qx,
    input  logic signed [WW-1:0] Wr_in,
    input  logic signed [WW-1:0] Wj_in,
    output logic                 out_valid,
    output logic signed [DW-1:0] Iy,
    output logic signed [DW-1:0] Qy,
    output logic signed [WW-1:0] Wr,
    output logic signed [WW-1:0] Wj,
    output logic                 settled
);
    localparam int PW = WW + DW + 2;
    localparam int DP = 2 * DW + 2;
    localparam int UW = WW + DP + 1;
    localparam logic signed [PW-1:0] OMAX = PW'(2 ** (DW - 1) - 1);
    localparam logic signed [PW-1:0] OMIN = PW'(-(2 ** (DW - 1)));
    localparam logic signed [UW-1:0] WMAX = UW'(2 ** (WW - 1) - 1);
    localparam logic signed [UW-1:0] WMIN = UW'(-(2 ** (WW - 1)));

    if (SETTLE_CNT < 1 || SETTLE_THR < 0 || MU < 0) begin : g_cfg_err
        $error("iq_comp_adapt: bad parameters");
    end

    typedef enum logic [2:0] {
        ST_BYP, ST_ADAPT, ST_HOLD, ST_EXT, ST_TRACK
    } state_t;

    state_t r_state, w_state_nx;
    logic signed [DW-1:0] r_iy, r_qy;
    logic signed [WW-1:0] r_wr, r_wj;
    logic                 r_ov;
    logic                 w_settle_go;
    logic                 w_upd;

    logic signed [DW-1:0] w_ixs, w_qxs;
    logic signed [WW-1:0] w_wr_use, w_wj_use;
    logic signed [PW-1:0] w_pi, w_pq, w_ci, w_cq;
    logic signed [DW:0]   w_s, w_d;
    logic signed [DP-1:0] w_dwr, w_dwj;
    logic signed [UW-1:0] w_wr_nx, w_wj_nx;

    function automatic logic signed [DW-1:0] sat_o(input logic signed [PW-1:0] v);
        if (v > OMAX) return DW'(OMAX);
        if (v < OMIN) return DW'(OMIN);
        return DW'(v);
    endfunction

    function automatic logic signed [WW-1:0] sat_w(input logic signed [UW-1:0] v);
        if (v > WMAX) return WW'(WMAX);
        if (v < WMIN) return WW'(WMIN);
        return WW'(v);
    endfunction

    // Offset-binary to two's complement is an MSB flip.
    assign w_ixs = $signed({~Ix[DW-1], Ix[DW-2:0]});
    assign w_qxs = $signed({~Qx[DW-1], Qx[DW-2:0]});

    assign w_wr_use = (r_state == ST_EXT) ? Wr_in : r_wr;
    assign w_wj_use = (r_state == ST_EXT) ? Wj_in : r_wj;

    assign w_pi = PW'(w_wr_use) * PW'(w_ixs) + PW'(w_wj_use) * PW'(w_qxs);
    assign w_pq = PW'(w_wj_use) * PW'(w_ixs) - PW'(w_wr_use) * PW'(w_qxs);
    assign w_ci = PW'(w_ixs) + (w_pi >>> MU);
    assign w_cq = PW'(w_qxs) + (w_pq >>> MU);

    assign w_s     = (DW+1)'(r_iy) + (DW+1)'(r_qy);
    assign w_d     = (DW+1)'(r_iy) - (DW+1)'(r_qy);
    assign w_dwr   = DP'(w_s) * DP'(w_d);
    assign w_dwj   = (DP'(r_iy) * DP'(r_qy)) <<< 1;
    assign w_wr_nx = UW'(r_wr) - UW'(w_dwr);
    assign w_wj_nx = UW'(r_wj) - UW'(w_dwj);

    assign w_upd = in_valid && ((r_state == ST_ADAPT && !freeze_iqcomp)
                                || r_state == ST_TRACK);

    always_comb begin
        w_state_nx = r_state;
        unique case (op_mode)
            2'b00: w_state_nx = ST_BYP;
            2'b10: w_state_nx = ST_EXT;
            2'b11: w_state_nx = ST_TRACK;
            default: begin
                if (r_state == ST_ADAPT || r_state == ST_HOLD)
                    w_state_nx = (freeze_iqcomp || w_settle_go) ? ST_HOLD : ST_ADAPT;
                else
                    w_state_nx = ST_ADAPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) r_state <= ST_BYP;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_ov <= 1'b0;
            r_iy <= '0;
            r_qy <= '0;
        end else begin
            r_ov <= in_valid;
            if (in_valid) begin
                r_iy <= (r_state == ST_BYP) ? w_ixs : sat_o(w_ci);
                r_qy <= (r_state == ST_BYP) ? w_qxs : sat_o(w_cq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_wr <= '0;
            r_wj <= '0;
        end else begin
            unique case (r_state)
                ST_BYP: begin
                    r_wr <= '0;
                    r_wj <= '0;
                end
                ST_EXT: begin
                    r_wr <= Wr_in;
                    r_wj <= Wj_in;
                end
                default: begin
                    if (w_upd) begin
                        r_wr <= sat_w(w_wr_nx);
                        r_wj <= sat_w(w_wj_nx);
                    end
                end
            endcase
        end
    end

`ifdef IQCOMP_SETTLE_DET_EN
    localparam int CW = $clog2(SETTLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CNT);
    localparam logic [CW-1:0] CNT_HIT = CW'(SETTLE_CNT - 1);
    localparam logic signed [DP-1:0] THR = DP'(SETTLE_THR);

    logic [CW-1:0] r_cnt;
    logic          r_settled;
    logic [1:0]    r_op_prev;
    logic          w_chg, w_small, w_adapt_upd, w_hit;

    assign w_chg       = (op_mode != r_op_prev);
    assign w_small     = (w_dwr <= THR) && (w_dwr >= -THR)
                      && (w_dwj <= THR) && (w_dwj >= -THR);
    assign w_adapt_upd = w_upd && (r_state == ST_ADAPT);
    assign w_hit       = w_adapt_upd && w_small && !w_chg && (r_cnt == CNT_HIT);
    assign w_settle_go = r_settled || w_hit;
    assign settled     = r_settled;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_settled <= 1'b0;
            r_op_prev <= 2'b00;
        end else begin
            r_op_prev <= op_mode;
            if (w_chg) begin
                r_cnt     <= '0;
                r_settled <= 1'b0;
            end else if (w_adapt_upd) begin
                if (!w_small)             r_cnt <= '0;
                else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
                if (w_hit) r_settled <= 1'b1;
            end
        end
    end
`else
    assign settled     = freeze_iqcomp;
    assign w_settle_go = 1'b0;
`endif

    assign out_valid = r_ov;
    assign Iy        = r_iy;
    assign Qy        = r_qy;
    assign Wr        = r_wr;
    assign Wj        = r_wj;
endmodule
